fir_tap_inverse: RTL and testbench
==================================

Name: fir_tap_inverse

Overview:
- Inverse (deconvolving) stage for the boxcar moving-sum FIR tap.
- Accepts the tapSize-sample running sum stream y[n] = x[n] + x[n-1] + ... + x[n-tapSize+1] and reconstructs the original samples x[n].
- Sits downstream of the FIR tap in loopback/self-check paths. Flags any sum sequence that does not decode to in-range samples.

Parameters:
- tapSize, 4, number of taps in the matching forward sum; power of two, >= 2.
- width, 4, bit width of each reconstructed sample x[n] (unsigned).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in; one sum sample consumed per cycle with in_valid=1.
- in  input  $clog2(tapSize)+width  unsigned running sum y[n].
- out_valid  output  1  qualifies out; registered.
- out  output  width  reconstructed sample x[n]; registered.
- err  output  1  sticky decode-error flag.
- busy  output  1  high while in RUN or FAULT state, i.e. at least one sample decoded since reset.

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset. No asynchronous logic.
- Reset, sampled at a rising edge, takes effect on that edge:
  - out_valid=0, out=0, err=0, busy=0, state=IDLE.
  - y_prev=0 and all tapSize history entries = 0.
  - Reset mid-stream discards all history. The next valid input is decoded as if it were the first sample (zero initial conditions).
- Recurrence, evaluated only on cycles with in_valid=1: x[n] = y[n] - y_prev + hist[tapSize-1].
  - hist[k] holds x[n-1-k].
  - y_prev is the previous accepted y. It is 0 before the first accepted sample.
- Arithmetic: evaluate in signed two's complement of width $clog2(tapSize)+width+2 bits (no intermediate wrap).
  - Result in range [0, 2^width-1]: out = result.
  - Result otherwise: out = result[width-1:0] (truncated) and err is set.
- Update on accepted sample, at the same edge:
  - out/out_valid registered with 1-cycle latency: out_valid=1 on the cycle after in_valid=1.
  - hist shifts: hist[0] <= out value (truncated), hist[k] <= hist[k-1].
  - y_prev <= in.
- in_valid=0 cycles: out_valid=0; out holds its last value; hist, y_prev and state are frozen. Gaps do not insert zeros, so the sample index advances only on accepted samples.
- State machine:
  - IDLE -> RUN on first accepted sample with in-range result.
  - IDLE or RUN -> FAULT on any out-of-range result.
  - FAULT is exit-only by reset; decoding continues in FAULT (out_valid still asserted).
  - err = (state==FAULT), registered, asserted in the same cycle as the offending out_valid.
  - busy = (state != IDLE).
- Back-to-back in_valid every cycle is supported at full throughput. There is no backpressure.
- Reset asserted in the same cycle as in_valid=1: reset wins and the sample is dropped.

Test Plan:
- Reset, then tapSize=4, width=4, in = 3, 8, 15, 16, 28, 23 on consecutive cycles -> out = 3, 5, 7, 1, 15, 0 each one cycle later; out_valid high 6 cycles; err=0; busy=1 from the first output.
- Same stream with in_valid low for 3 cycles between 15 and 16 -> identical out sequence; out_valid low during the gap; out holds 7 during the gap.
- in = 10 then 2 -> first out=10; second result -8 -> out=8 (truncated), err=1 from that cycle, state FAULT; further in=2 -> out=0, err stays 1.
- in = 20 first after reset -> result 20 > 15 -> out=4, err=1.
- Send 3, 8, 15; assert reset for one cycle; then send 5 -> out_valid=0 and err=0 during reset; post-reset out=5 (history cleared, not 5-15+0).
- in_valid=1 with in=9 in the same cycle as reset=1 -> no out_valid on the following cycle; next valid in=9 decodes to out=9.

Source files
------------

// File: rtl/fir_tap_inverse.sv
// Inverse of the boxcar moving-sum FIR tap: rebuilds x[n] from the running
// sum y[n] via x[n] = y[n] - y[n-1] + x[n-tapSize], and flags any sum stream
// that does not decode to in-range unsigned samples.
module fir_tap_inverse #(
    parameter int unsigned tapSize = 4,
    parameter int unsigned width   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [$clog2(tapSize)+width-1:0]  in,
    output logic                              out_valid,
    output logic [width-1:0]                  out,
    output logic                              err,
    output logic                              busy
);

    // Sum width, and the signed evaluation width with headroom so that the
    // three-term recurrence never wraps before the range check.
    localparam int unsigned SW = $clog2(tapSize) + width;
    localparam int unsigned AW = SW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SW-1:0]        y_prev_q;
    logic [width-1:0]     hist_q [tapSize];
    logic                 out_valid_q;
    logic [width-1:0]     out_q;
    logic                 err_q;
    logic                 busy_q;

    logic signed [AW-1:0] res_c;
    logic                 in_range_c;
    logic [width-1:0]     x_d;

    // Recurrence, range check and next decoder state for the current input.
    always_comb begin
        res_c      = signed'(AW'(in)) - signed'(AW'(y_prev_q))
                   + signed'(AW'(hist_q[tapSize-1]));
        // In range exactly when every bit above the sample width is zero
        // (this also rejects negative results via the sign bit).
        in_range_c = (res_c[AW-1:width] == '0);
        x_d        = res_c[width-1:0];
        state_d    = state_q;
        if (in_valid) begin
            if (!in_range_c) begin
                state_d = FAULT;
            end else if (state_q == IDLE) begin
                state_d = RUN;
            end
        end
    end

    // Decoder state, sample history and registered outputs; gaps freeze
    // everything except out_valid so the sample index only advances on
    // accepted inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            y_prev_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < int'(tapSize); k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q    <= x_d;
                y_prev_q <= in;
                hist_q[0] <= x_d;
                for (int k = 1; k < int'(tapSize); k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
                state_q  <= state_d;
                err_q    <= (state_d == FAULT);
                busy_q   <= (state_d != IDLE);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_tap_inverse.sv
// Directed vector bench for fir_tap_inverse (tapSize=4, width=4).
module tb_fir_tap_inverse;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [5:0] in_s;
    logic       out_valid;
    logic [3:0] out_s;
    logic       err;
    logic       busy;

    int errors;
    int checks;

    fir_tap_inverse #(.tapSize(4), .width(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_s),
        .out_valid (out_valid),
        .out       (out_s),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock: inputs driven before the edge, outputs expected after it.
    typedef struct {
        logic       rst;
        logic       vld;
        logic [5:0] y;
        logic       e_ov;
        logic [3:0] e_out;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic vld, logic [5:0] y,
                                logic e_ov, logic [3:0] e_out,
                                logic e_err, logic e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.y = y;
        v.e_ov = e_ov; v.e_out = e_out; v.e_err = e_err; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic check1(string name, int idx, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(logic rst, logic vld, logic [5:0] y);
        reset    = rst;
        in_valid = vld;
        in_s     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(int idx, logic e_ov, logic [3:0] e_out,
                             logic e_err, logic e_busy);
        check1("out_valid", idx, 4'(out_valid), 4'(e_ov));
        check1("out",       idx, out_s,         e_out);
        check1("err",       idx, 4'(err),       4'(e_err));
        check1("busy",      idx, 4'(busy),      4'(e_busy));
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_s     = '0;

        // Basic stream: 3,8,15,16,28,23 -> 3,5,7,1,15,0
        add(1,0, 0, 0, 0,0,0);
        add(0,1, 3, 1, 3,0,1);
        add(0,1, 8, 1, 5,0,1);
        add(0,1,15, 1, 7,0,1);
        add(0,1,16, 1, 1,0,1);
        add(0,1,28, 1,15,0,1);
        add(0,1,23, 1, 0,0,1);
        add(0,0, 0, 0, 0,0,1);
        // Same stream with a 3-cycle gap between 15 and 16
        add(1,0, 0, 0, 0,0,0);
        add(0,1, 3, 1, 3,0,1);
        add(0,1, 8, 1, 5,0,1);
        add(0,1,15, 1, 7,0,1);
        add(0,0,33, 0, 7,0,1);
        add(0,0,40, 0, 7,0,1);
        add(0,0, 1, 0, 7,0,1);
        add(0,1,16, 1, 1,0,1);
        add(0,1,28, 1,15,0,1);
        add(0,1,23, 1, 0,0,1);
        // Negative result: 10, 2 -> 10, 8 (err), then 2 -> 0 (err sticky)
        add(1,0, 0, 0, 0,0,0);
        add(0,1,10, 1,10,0,1);
        add(0,1, 2, 1, 8,1,1);
        add(0,1, 2, 1, 0,1,1);
        add(0,0, 0, 0, 0,1,1);
        // Overflow on the first sample: 20 -> 4 with err
        add(1,0, 0, 0, 0,0,0);
        add(0,1,20, 1, 4,1,1);
        // Reset mid-stream clears history
        add(1,0, 0, 0, 0,0,0);
        add(0,1, 3, 1, 3,0,1);
        add(0,1, 8, 1, 5,0,1);
        add(0,1,15, 1, 7,0,1);
        add(1,0, 0, 0, 0,0,0);
        add(0,1, 5, 1, 5,0,1);
        // Reset together with a valid input drops the input
        add(1,1, 9, 0, 0,0,0);
        add(0,1, 9, 1, 9,0,1);
        // Range boundaries: 0 and 15 decode cleanly, 15+16 overflows
        add(1,0, 0, 0, 0,0,0);
        add(0,1, 0, 1, 0,0,1);
        add(0,1,15, 1,15,0,1);
        add(0,1,46, 1,15,1,1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].y);
            check_all(i, vecs[i].e_ov, vecs[i].e_out, vecs[i].e_err, vecs[i].e_busy);
        end

        // Hand sequence: full window wrap with gaps between every sample,
        // then reset arriving with a valid input mid-stream.
        // x = 2,4,6,1,3 -> y = 2,6,12,13,14
        step(1, 0, 0);
        check_all(100, 0, 0, 0, 0);
        step(0, 1, 2);   check_all(101, 1, 2, 0, 1);
        step(0, 0, 0);   check_all(102, 0, 2, 0, 1);
        step(0, 1, 6);   check_all(103, 1, 4, 0, 1);
        step(0, 0, 0);   check_all(104, 0, 4, 0, 1);
        step(0, 1, 12);  check_all(105, 1, 6, 0, 1);
        step(0, 1, 13);  check_all(106, 1, 1, 0, 1);
        step(0, 0, 0);   check_all(107, 0, 1, 0, 1);
        step(0, 1, 14);  check_all(108, 1, 3, 0, 1);
        step(1, 1, 20);  check_all(109, 0, 0, 0, 0);
        step(0, 1, 7);   check_all(110, 1, 7, 0, 1);
        step(0, 0, 0);   check_all(111, 0, 7, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
